// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett reduction final stage: FSM states,
// digit-count helper and the residue width offset.
package barrett_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_SUB   = 3'd2,
        ST_CORR1 = 3'd3,
        ST_CORR2 = 3'd4
    } state_t;

    // Residue is kept two bits wider than the modulus so a - gamma*m stays
    // unambiguous when gamma underestimates the quotient by up to two.
    localparam int W_OFFSET = 2;

    function automatic int calc_nd(input int radix, input int digit);
        return (radix + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/mul_digit_serial.sv
// Digit-serial gamma*m accumulator, LSB digit first, wrapping modulo 2^W.
// Owns the accumulator and digit counter; 'last' marks the final digit.
module mul_digit_serial
    import barrett_pkg::*;
#(
    parameter int mul_size = 80,
    parameter int radix    = 78,
    parameter int DIGIT    = 16,
    localparam int ND      = calc_nd(radix, DIGIT),
    localparam int GW      = ND * DIGIT,
    localparam int W       = mul_size + W_OFFSET
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step,
    input  logic [GW-1:0]       gamma,
    input  logic [mul_size-1:0] m,
    output logic [W-1:0]        acc,
    output logic                last
);

    localparam int CNT_W = (ND > 1) ? $clog2(ND) : 1;

    logic [CNT_W-1:0]          cnt;
    logic [DIGIT-1:0]          digit;
    logic [DIGIT+mul_size-1:0] prod;
    logic [W-1:0]              term;

    always_comb begin
        digit = gamma[cnt*DIGIT +: DIGIT];
        prod  = {{mul_size{1'b0}}, digit} * {{DIGIT{1'b0}}, m};
        // Truncating before the shift is safe: only the low W bits survive anyway.
        term  = W'(prod) << (DIGIT * cnt);
        last  = (cnt == CNT_W'(ND - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= acc + term;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/barrett_subtract.sv
// Barrett final stage: r = a - gamma*m (mod 2^W), then two conditional
// subtractions of m. Optional BARRETT_SUB_CHECK_EN adds the 'err' output.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for en_sub, operands captured on start
// ST_MUL   | one gamma digit per cycle into the accumulator
// ST_SUB   | r = a - acc, W-bit wrap-around
// ST_CORR1 | first conditional r -= m
// ST_CORR2 | second conditional r -= m, load result, pulse valid
module barrett_subtract
    import barrett_pkg::*;
#(
    parameter int mul_size = 80,
    parameter int radix    = 78,
    parameter int DIGIT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_sub,
    input  logic [radix-1:0]      gamma,
    input  logic [2*mul_size-1:0] reg_a,
    input  logic [mul_size-1:0]   reg_m,
    output logic [mul_size-1:0]   result,
    output logic                  valid,
    output logic                  busy
`ifdef BARRETT_SUB_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int ND = calc_nd(radix, DIGIT);
    localparam int GW = ND * DIGIT;
    localparam int W  = mul_size + W_OFFSET;

    state_t              state;
    logic [GW-1:0]       gamma_q;
    logic [W-1:0]        a_q;
    logic [mul_size-1:0] m_q;
    logic [W-1:0]        r;
    logic [W-1:0]        acc;
    logic [W-1:0]        m_ext;
    logic [W-1:0]        r_corr;
    logic                mul_last;
    logic                start;
    logic                step;
    logic                unused_reg_a;

    assign unused_reg_a = ^reg_a[2*mul_size-1:W];

    always_comb begin
        start  = (state == ST_IDLE) && en_sub;
        step   = (state == ST_MUL);
        m_ext  = {{W_OFFSET{1'b0}}, m_q};
        r_corr = (r >= m_ext) ? (r - m_ext) : r;
    end

    mul_digit_serial #(
        .mul_size (mul_size),
        .radix    (radix),
        .DIGIT    (DIGIT)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .step  (step),
        .gamma (gamma_q),
        .m     (m_q),
        .acc   (acc),
        .last  (mul_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gamma_q <= '0;
            a_q     <= '0;
            m_q     <= '0;
            r       <= '0;
            result  <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
`ifdef BARRETT_SUB_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_sub) begin
                        gamma_q <= GW'(gamma);
                        a_q     <= reg_a[W-1:0];
                        m_q     <= reg_m;
                        busy    <= 1'b1;
                        state   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r     <= a_q - acc;
                    state <= ST_CORR1;
                end
                ST_CORR1: begin
                    r     <= r_corr;
                    state <= ST_CORR2;
                end
                ST_CORR2: begin
                    r      <= r_corr;
                    result <= r_corr[mul_size-1:0];
`ifdef BARRETT_SUB_CHECK_EN
                    // Still >= m after two corrections: gamma was off by more than 2.
                    err    <= (r_corr >= m_ext);
`endif
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
